// File: rtl/pixel_obi_mem_pipe.sv
// OBI slave returning address-derived pixel words RD_LATENCY cycles after grant, in grant order, up to MAX_OUTSTANDING in flight.
// rvalid/rdata hold while !rready; `define PIXEL_OBI_MEM_ERR_EN adds an err port flagging addr >= ADDR_LIMIT.
module pixel_obi_mem_pipe #(
    parameter int          WORD_WIDTH      = 32,
    parameter int          DATA_WIDTH      = 16,
    parameter logic [31:0] VALUE_MASK      = 32'h0000_3FFF,
    parameter int          RD_LATENCY      = 2,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [15:0] GNT_SEED        = 16'hACE1,
    parameter logic [31:0] ADDR_LIMIT      = 32'h0001_0000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req,
    input  logic                                 we,
    input  logic [WORD_WIDTH-1:0]                addr,
    input  logic [WORD_WIDTH-1:0]                wdata,
    input  logic [WORD_WIDTH/8-1:0]              be,
    output logic                                 gnt,
    output logic                                 rvalid,
    output logic [WORD_WIDTH-1:0]                rdata,
    input  logic                                 rready,
    input  logic                                 random_gnt,
`ifdef PIXEL_OBI_MEM_ERR_EN
    output logic                                 err,
`endif
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding
);

    localparam int PIXELS     = WORD_WIDTH / DATA_WIDTH;
    localparam int BYTE_SHIFT = $clog2(WORD_WIDTH / 8);
    localparam int CW         = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW         = $clog2(MAX_OUTSTANDING);

    typedef struct packed {
        logic                  err;
        logic [WORD_WIDTH-1:0] dat;
    } entry_t;

    logic [15:0]           lfsr;
    logic [CW-1:0]         out_q;
    logic                  hs;
    logic                  pop;
    logic                  push_vld;
    entry_t                push_ent;
    entry_t                in_ent;
    logic [WORD_WIDTH-1:0] word;
    logic [WORD_WIDTH-1:0] lane;

    assign gnt = rst_n && req && (out_q < CW'(MAX_OUTSTANDING)) && (!random_gnt || lfsr[0]);
    assign hs  = req && gnt;
    assign outstanding = out_q;

    // Response payload is fixed at the handshake, so later address changes cannot leak in.
    always_comb begin
        word   = addr >> BYTE_SHIFT;
        lane   = '0;
        in_ent = '0;
        for (int i = 0; i < PIXELS; i++) begin
            lane = (word * WORD_WIDTH'(PIXELS) + WORD_WIDTH'(i)) & WORD_WIDTH'(VALUE_MASK);
            in_ent.dat[i*DATA_WIDTH +: DATA_WIDTH] = lane[DATA_WIDTH-1:0];
        end
        if (we) in_ent.dat = '0;
`ifdef PIXEL_OBI_MEM_ERR_EN
        if (addr >= WORD_WIDTH'(ADDR_LIMIT)) begin
            in_ent.dat = '0;
            in_ent.err = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr <= GNT_SEED;
        else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) out_q <= '0;
        else if (hs && !pop) out_q <= out_q + 1'b1;
        else if (!hs && pop) out_q <= out_q - 1'b1;
    end

    // The FIFO write itself is the final latency stage, hence RD_LATENCY-1 registers here.
    generate
        if (RD_LATENCY == 1) begin : g_direct
            assign push_vld = hs;
            assign push_ent = in_ent;
        end else begin : g_pipe
            logic [RD_LATENCY-2:0] pv;
            entry_t                pd [RD_LATENCY-1];
            always_ff @(posedge clk) begin
                if (!rst_n) pv <= '0;
                else        pv <= {pv, hs};
            end
            always_ff @(posedge clk) begin
                pd[0] <= in_ent;
                for (int k = 1; k < RD_LATENCY - 1; k++) pd[k] <= pd[k-1];
            end
            assign push_vld = pv[RD_LATENCY-2];
            assign push_ent = pd[RD_LATENCY-2];
        end
    endgenerate

    entry_t                mem [MAX_OUTSTANDING];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fcnt;
    logic [WORD_WIDTH-1:0] rdata_hold;
    entry_t                head;

    assign head   = mem[rd_ptr];
    assign rvalid = (fcnt != '0);
    assign pop    = rvalid && rready;
    assign rdata  = rvalid ? head.dat : rdata_hold;

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_ent;
    end

    // Never overflows: every entry in the pipe or FIFO is counted in out_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fcnt       <= '0;
            rdata_hold <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                rdata_hold <= head.dat;
            end
            if (push_vld && !pop)      fcnt <= fcnt + 1'b1;
            else if (!push_vld && pop) fcnt <= fcnt - 1'b1;
        end
    end

`ifdef PIXEL_OBI_MEM_ERR_EN
    assign err = rvalid && head.err;
    logic unused_inputs;
    assign unused_inputs = ^{wdata, be};
`else
    logic unused_inputs;
    assign unused_inputs = ^{wdata, be, head.err};
`endif

endmodule

// File: tb/tb_pixel_obi_mem_pipe.sv
// Directed-plus-random bench for pixel_obi_mem_pipe with a queue-based reference of in-order, latency-timed responses.
module tb_pixel_obi_mem_pipe;

    localparam int          L     = 2;
    localparam int          MAXO  = 4;
    localparam logic [31:0] MASK  = 32'h0000_3FFF;
    localparam logic [31:0] LIMIT = 32'h0001_0000;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n, req, we, rready, random_gnt;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic        gnt, rvalid;
    logic [2:0]  outstanding;
`ifdef PIXEL_OBI_MEM_ERR_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_obi_mem_pipe dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rready(rready), .random_gnt(random_gnt),
`ifdef PIXEL_OBI_MEM_ERR_EN
        .err(err),
`endif
        .outstanding(outstanding)
    );

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc, m_out, m_pops, grants;
    logic [15:0] m_lfsr;
    logic [31:0] m_last;
    logic        m_hs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane i of word w is (w*2+i) masked, with 32-bit wraparound.
    function automatic logic [31:0] pix(input logic [31:0] a);
        logic [31:0] w, l0, l1;
        w  = a / 4;
        l0 = (w * 2) & MASK;
        l1 = (w * 2 + 1) & MASK;
        return {l1[15:0], l0[15:0]};
    endfunction

    task automatic tick();
        logic        e_gnt, e_vld, s_we;
        logic [31:0] s_addr;
        exp_t        e;
        @(negedge clk);
        s_we   = we;
        s_addr = addr;
        e_gnt  = rst_n && req && (m_out < MAXO) && (!random_gnt || m_lfsr[0]);
        e_vld  = (q.size() > 0) && (q[0].due <= cyc);
        chk("gnt", gnt, e_gnt);
        chk("rvalid", rvalid, e_vld);
        chk("outstanding", outstanding, m_out);
        if (e_vld) chk("rdata", rdata, q[0].dat);
        else       chk("rdata_hold", rdata, m_last);
`ifdef PIXEL_OBI_MEM_ERR_EN
        if (e_vld) chk("err", err, q[0].err);
`endif
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_out  = 0;
            m_lfsr = SEED;
            m_last = '0;
        end else begin
            if (e_vld && rready) begin
                m_last = q[0].dat;
                void'(q.pop_front());
                m_out--;
                m_pops++;
            end
            if (e_gnt) begin
                e.dat = s_we ? 32'h0 : pix(s_addr);
                e.err = 1'b0;
`ifdef PIXEL_OBI_MEM_ERR_EN
                if (s_addr >= LIMIT) begin
                    e.dat = 32'h0;
                    e.err = 1'b1;
                end
`endif
                e.due = cyc + L;
                q.push_back(e);
                m_out++;
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
        m_hs = e_gnt;
        cyc++;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        rready = 1'b1; random_gnt = 1'b0;
        @(posedge clk);
        #1;
        q.delete(); m_out = 0; m_lfsr = SEED; m_last = '0; cyc = 0; m_pops = 0; m_hs = 1'b0;

        // Reset state
        tick();
        rst_n = 1'b1;

        // Basic read at address 8
        req = 1'b1; addr = 32'h0000_0008;
        tick();
        req = 1'b0;
        tick();
        chk("basic_rvalid", rvalid, 1'b1);
`ifdef PIXEL_OBI_MEM_ERR_EN
        chk("basic_rdata", rdata, 32'h0005_0004);
`else
        chk("basic_rdata", rdata, 32'h0005_0004);
`endif
        repeat (3) tick();

        // Mask and wrap
        req = 1'b1; addr = 32'h0001_FFFC;
        tick();
        req = 1'b0;
        tick();
        chk("wrap_rvalid", rvalid, 1'b1);
`ifdef PIXEL_OBI_MEM_ERR_EN
        chk("wrap_rdata", rdata, 32'h0);
        chk("wrap_err", err, 1'b1);
`else
        chk("wrap_rdata", rdata, 32'h3FFF_3FFE);
`endif
        repeat (3) tick();

        // Outstanding limit with the consumer stalled
        rready = 1'b0; req = 1'b1; addr = 32'h0000_0040; grants = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_hs) begin grants++; addr = addr + 4; end
        end
        chk("limit_grants", grants, 4);
        chk("limit_outstanding", outstanding, 4);
        chk("limit_gnt", gnt, 1'b0);
        rready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m_hs) begin grants++; addr = addr + 4; end
        end
        chk("limit_resumed", grants > 4, 1'b1);
        req = 1'b0;
        repeat (8) tick();

        // Back-pressure with rready toggling across 8 back-to-back reads
        m_pops = 0;
        begin
            int idx;
            idx = 0; req = 1'b1; addr = 32'h0;
            for (int i = 0; i < 40; i++) begin
                rready = (i % 2 == 0);
                tick();
                if (m_hs) begin
                    idx++;
                    addr = idx * 4;
                    if (idx == 8) req = 1'b0;
                end
            end
        end
        chk("bp_responses", m_pops, 8);
        rready = 1'b1;

        // Random grant with random addresses, writes and rready
        random_gnt = 1'b1; req = 1'b1; m_pops = 0; grants = 0;
        addr = $urandom; we = $urandom_range(0, 1);
        for (int i = 0; i < 100; i++) begin
            rready = ($urandom_range(0, 3) != 0);
            tick();
            if (m_hs) begin
                grants++;
                addr = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 32'h0001_FFFF);
                we = $urandom_range(0, 1);
            end
        end
        req = 1'b0; we = 1'b0; rready = 1'b1;
        repeat (10) tick();
        chk("rand_no_loss", m_pops, grants);
        chk("rand_drained", outstanding, 0);
        random_gnt = 1'b0;

        // Reset with three reads in flight
        rready = 1'b0; req = 1'b1; addr = 32'h0000_0100; grants = 0;
        while (grants < 3) begin
            tick();
            if (m_hs) begin grants++; addr = addr + 4; end
        end
        req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        rready = 1'b1;
        repeat (8) tick();

`ifdef PIXEL_OBI_MEM_ERR_EN
        req = 1'b1; addr = LIMIT;
        tick();
        req = 1'b0;
        tick();
        chk("err_flag", err, 1'b1);
        chk("err_rdata", rdata, 32'h0);
        repeat (3) tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
